// File: rtl/seg7_hex_scan.sv
// Multiplexed hex seven-segment driver. It snapshots din once per frame so
// that a frame never shows digits from two different values. It then scans
// the digits with active-low anodes and segments. Each digit slot begins with
// one all-dark cycle, so the previous digit does not ghost onto the next anode.

// Single-digit decoder: nibble to active-low {g,f,e,d,c,b,a}. It also handles
// leading-zero blanking. POS==0 is the least significant digit, which always
// stays visible.
module seg7_hex_scan_digit #(
    parameter int POS = 0
) (
    input  logic [3:0] nib,
    input  logic       upper_zero,
    input  logic       blank_lz,
    output logic [6:0] seg
);
    logic [6:0] raw;

    // hex glyph lookup
    always_comb begin
        raw = 7'h7F;
        case (nib)
            4'h0: raw = 7'h40;
            4'h1: raw = 7'h79;
            4'h2: raw = 7'h24;
            4'h3: raw = 7'h30;
            4'h4: raw = 7'h19;
            4'h5: raw = 7'h12;
            4'h6: raw = 7'h02;
            4'h7: raw = 7'h78;
            4'h8: raw = 7'h00;
            4'h9: raw = 7'h10;
            4'hA: raw = 7'h08;
            4'hB: raw = 7'h03;
            4'hC: raw = 7'h46;
            4'hD: raw = 7'h21;
            4'hE: raw = 7'h06;
            4'hF: raw = 7'h0E;
            default: raw = 7'h7F;
        endcase
    end

    assign seg = (POS != 0 && blank_lz && upper_zero) ? 7'h7F : raw;
endmodule

module seg7_hex_scan #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,       // active-high, asynchronous
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    hold,
    input  logic                    blank_lz,
    output logic [DATA_WIDTH/4-1:0] an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);
    localparam int DIGITS = DATA_WIDTH / 4;
    localparam int PW     = $clog2(CLK_DIV);
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]              presc;
    logic [IW-1:0]              idx;
    logic [DATA_WIDTH-1:0]      snap;
    logic                       tick;
    logic                       last_dig;
    logic [DIGITS-1:0][6:0]     dig_seg;

    assign tick     = (presc == PW'(CLK_DIV - 1));
    assign last_dig = (idx == IW'(DIGITS - 1));

    // One decoder per digit. Each decoder sees whether every nibble from its
    // position upward is zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        seg7_hex_scan_digit #(.POS(i)) u_dig (
            .nib        (snap[4*i +: 4]),
            .upper_zero (~|snap[DATA_WIDTH-1:4*i]),
            .blank_lz   (blank_lz),
            .seg        (dig_seg[i])
        );
    end

    // slot prescaler and digit index
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
                idx <= last_dig ? '0 : idx + IW'(1);
        end
    end

    // frame-boundary snapshot and frame pulse; hold freezes the snapshot
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            snap       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= tick && last_dig;
            if (tick && last_dig && !hold)
                snap <= din;
        end
    end

    // registered display outputs: dark on tick cycles, current digit otherwise
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (tick) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= dig_seg[idx];
            dp  <= ~(idx == '0 && hold);
        end
    end
endmodule
